// File: rtl/aes_encrypt_host.sv
// Bus initiator for the AES encrypt register port: writes a plaintext/key job
// as eight words, starts the core, waits for finish and reads back the ciphertext.
module aes_encrypt_host #(
  parameter int TIMEOUT = 1023,
  parameter int TW      = 10
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [127:0] s_plain,
  input  logic [127:0] s_key,
  input  logic         s_key_reuse,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [127:0] m_cipher,
  output logic         err,
  output logic         wr,
  output logic [2:0]   waddr,
  output logic [31:0]  wdata,
  output logic [1:0]   raddr,
  input  logic [31:0]  rdata,
  output logic         start,
  input  logic         finish,
  input  logic         bus_free
);

  typedef enum logic [2:0] {
    IDLE, WR_PT, WR_KEY, WAIT_FREE, START, WAIT_FIN, RD, OUT
  } state_t;

  state_t         state, state_n;
  logic [1:0]     beat, beat_n;
  logic [TW-1:0]  cnt, cnt_n;
  logic [127:0]   plain_q, plain_n, key_q, key_n;
  logic           skip_key, skip_n, key_loaded, kl_n;
  logic           wr_n, start_n, mv_n, err_n;
  logic [2:0]     waddr_n;
  logic [31:0]    wdata_n;
  logic [1:0]     raddr_n;
  logic [127:0]   mc_n;
  logic           tmo_hit;

  // A TIMEOUT of zero never expires; otherwise TIMEOUT cycles are allowed in a wait state.
  assign tmo_hit = (TIMEOUT != 0) && (cnt == TW'(TIMEOUT - 1));
  assign s_ready = (state == IDLE);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      beat       <= '0;
      cnt        <= '0;
      plain_q    <= '0;
      key_q      <= '0;
      skip_key   <= 1'b0;
      key_loaded <= 1'b0;
      wr         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      raddr      <= '0;
      start      <= 1'b0;
      m_valid    <= 1'b0;
      m_cipher   <= '0;
      err        <= 1'b0;
    end else begin
      state      <= state_n;
      beat       <= beat_n;
      cnt        <= cnt_n;
      plain_q    <= plain_n;
      key_q      <= key_n;
      skip_key   <= skip_n;
      key_loaded <= kl_n;
      wr         <= wr_n;
      waddr      <= waddr_n;
      wdata      <= wdata_n;
      raddr      <= raddr_n;
      start      <= start_n;
      m_valid    <= mv_n;
      m_cipher   <= mc_n;
      err        <= err_n;
    end
  end

  // Next-state logic also computes the next value of every registered port output.
  always_comb begin
    state_n = state;
    beat_n  = beat;
    cnt_n   = cnt;
    plain_n = plain_q;
    key_n   = key_q;
    skip_n  = skip_key;
    kl_n    = key_loaded;
    wr_n    = 1'b0;
    waddr_n = waddr;
    wdata_n = wdata;
    raddr_n = raddr;
    start_n = 1'b0;
    mv_n    = m_valid;
    mc_n    = m_cipher;
    err_n   = err;
    case (state)
      IDLE: begin
        if (s_valid) begin
          plain_n = s_plain;
          key_n   = s_key;
          skip_n  = s_key_reuse & key_loaded;
          err_n   = 1'b0;
          state_n = WR_PT;
          beat_n  = 2'd0;
          wr_n    = 1'b1;
          waddr_n = 3'd0;
          wdata_n = s_plain[31:0];
        end
      end
      WR_PT: begin
        if (beat != 2'd3) begin
          beat_n  = beat + 1'b1;
          wr_n    = 1'b1;
          waddr_n = {1'b0, beat_n};
          wdata_n = plain_q[32*beat_n +: 32];
        end else if (skip_key) begin
          state_n = WAIT_FREE;
          cnt_n   = '0;
        end else begin
          state_n = WR_KEY;
          beat_n  = 2'd0;
          wr_n    = 1'b1;
          waddr_n = 3'd4;
          wdata_n = key_q[31:0];
        end
      end
      WR_KEY: begin
        if (beat != 2'd3) begin
          beat_n  = beat + 1'b1;
          wr_n    = 1'b1;
          waddr_n = {1'b1, beat_n};
          wdata_n = key_q[32*beat_n +: 32];
        end else begin
          kl_n    = 1'b1;
          state_n = WAIT_FREE;
          cnt_n   = '0;
        end
      end
      WAIT_FREE: begin
        if (bus_free) begin
          state_n = START;
          start_n = 1'b1;
        end else if (tmo_hit) begin
          err_n   = 1'b1;
          kl_n    = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      // finish is deliberately not looked at here: a level left over from the previous job is stale.
      START: begin
        state_n = WAIT_FIN;
        cnt_n   = '0;
      end
      WAIT_FIN: begin
        if (finish) begin
          state_n = RD;
          beat_n  = 2'd0;
          raddr_n = 2'd0;
        end else if (tmo_hit) begin
          err_n   = 1'b1;
          kl_n    = 1'b0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RD: begin
        mc_n[32*beat +: 32] = rdata;
        if (beat != 2'd3) begin
          beat_n  = beat + 1'b1;
          raddr_n = beat_n;
        end else begin
          mv_n    = 1'b1;
          state_n = OUT;
        end
      end
      OUT: begin
        if (m_ready) begin
          mv_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_encrypt_host.sv
// Self-checking bench for aes_encrypt_host: behavioural AES core on the bus side,
// table-driven jobs with a ciphertext scoreboard, plus timeout and reset sequences.
module tb_aes_encrypt_host;

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         s_valid = 1'b0, s_ready, s_key_reuse = 1'b0;
  logic [127:0] s_plain = '0, s_key = '0;
  logic         m_valid, m_ready = 1'b1, err;
  logic [127:0] m_cipher;
  logic         wr, start, bus_free;
  logic         finish = 1'b0;
  logic [2:0]   waddr;
  logic [31:0]  wdata, rdata;
  logic [1:0]   raddr;

  logic         t_s_valid = 1'b0, t_s_ready, t_m_valid, t_err, t_wr, t_start;
  logic [127:0] t_m_cipher;
  logic [2:0]   t_waddr;
  logic [31:0]  t_wdata;
  logic [1:0]   t_raddr;
  logic [31:0]  t_rdata = '0;
  logic         t_finish = 1'b0, t_bus_free = 1'b1;

  always #5 clk = ~clk;

  aes_encrypt_host dut (
    .clk(clk), .nrst(nrst), .s_valid(s_valid), .s_ready(s_ready), .s_plain(s_plain),
    .s_key(s_key), .s_key_reuse(s_key_reuse), .m_valid(m_valid), .m_ready(m_ready),
    .m_cipher(m_cipher), .err(err), .wr(wr), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata), .start(start), .finish(finish), .bus_free(bus_free)
  );

  aes_encrypt_host #(.TIMEOUT(15), .TW(10)) dut_to (
    .clk(clk), .nrst(nrst), .s_valid(t_s_valid), .s_ready(t_s_ready), .s_plain(s_plain),
    .s_key(s_key), .s_key_reuse(s_key_reuse), .m_valid(t_m_valid), .m_ready(m_ready),
    .m_cipher(t_m_cipher), .err(t_err), .wr(t_wr), .waddr(t_waddr), .wdata(t_wdata),
    .raddr(t_raddr), .rdata(t_rdata), .start(t_start), .finish(t_finish), .bus_free(t_bus_free)
  );

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++)
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^
           {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  // Reference AES-128; byte 0 of the state is bit range [127:120].
  function automatic logic [127:0] aes128(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [7:0]   s [16];
    logic [7:0]   u [16];
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = {sbox(t[23:16]) ^ rc, sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) u[i] = sbox(s[4*((i/4 + i%4) % 4) + i%4]);
      for (int c = 0; c < 4; c++) begin
        a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
        if (r < 10) begin
          s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end else begin
          s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // Behavioural encrypt core; finish is a level that drops only when the next start arrives.
  logic [31:0]  core_regs [8];
  logic [127:0] core_ct = '0;
  logic         core_busy = 1'b0;
  logic         bus_free_en = 1'b1;
  int           fin_cnt = 0;
  int           finish_lat = 1;
  int           start_cnt = 0, mv_cycles = 0, cyc = 0;
  int           t_beat_cnt = 0, t_mv_cycles = 0;
  logic [34:0]  beat_log [$];

  assign bus_free = bus_free_en & ~core_busy;
  assign rdata    = core_ct[32*raddr +: 32];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_valid) mv_cycles++;
    if (t_wr) t_beat_cnt++;
    if (t_m_valid) t_mv_cycles++;
    if (wr) begin
      core_regs[waddr] <= wdata;
      beat_log.push_back({waddr, wdata});
    end
    if (start) begin
      start_cnt++;
      core_ct <= aes128({core_regs[3], core_regs[2], core_regs[1], core_regs[0]},
                        {core_regs[7], core_regs[6], core_regs[5], core_regs[4]});
      if (finish_lat <= 1) begin
        finish    <= 1'b1;
        core_busy <= 1'b0;
      end else begin
        finish    <= 1'b0;
        core_busy <= 1'b1;
        fin_cnt   <= finish_lat - 1;
      end
    end else if (core_busy) begin
      if (fin_cnt == 1) begin
        finish    <= 1'b1;
        core_busy <= 1'b0;
      end else begin
        fin_cnt <= fin_cnt - 1;
      end
    end
  end

  int           vectors = 0, miscompares = 0;
  logic [127:0] exp_q [$];
  logic [127:0] mdl_key = '0;
  bit           mdl_kl = 1'b0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one job, waits for acceptance and pushes the expected ciphertext.
  task automatic applyStimulus(input logic [127:0] p, input logic [127:0] k, input bit reuse,
                               output int acc);
    int  n;
    bit  use_old;
    @(negedge clk);
    s_plain = p; s_key = k; s_key_reuse = reuse; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      checkOutput("accept_wait", s_ready, 1);
      s_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    s_valid = 1'b0;
    use_old = reuse && mdl_kl;
    exp_q.push_back(aes128(p, use_old ? mdl_key : k));
    if (!use_old) begin
      mdl_key = k;
      mdl_kl  = 1'b1;
    end
  endtask

  task automatic collectResult(input int acc, input int exp_lat, input int exp_beats,
                               input int bbase, input int sbase,
                               input logic [127:0] p, input logic [127:0] k);
    int          n;
    bit          ok;
    logic [34:0] exp_e;
    logic [127:0] exp_ct;
    n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!m_valid) begin
      checkOutput("m_valid_wait", m_valid, 1);
      return;
    end
    if (exp_lat >= 0) checkOutput("latency", 128'(cyc - acc), 128'(exp_lat));
    exp_ct = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
    checkOutput("cipher", m_cipher, exp_ct);
    checkOutput("wr_beats", 128'(beat_log.size() - bbase), 128'(exp_beats));
    ok = 1'b1;
    for (int i = 0; i < exp_beats && bbase + i < beat_log.size(); i++) begin
      exp_e = {3'(i), (i < 4) ? p[32*i +: 32] : k[32*(i-4) +: 32]};
      if (beat_log[bbase + i] !== exp_e) ok = 1'b0;
    end
    checkOutput("wr_sequence", ok, 1);
    checkOutput("start_pulses", 128'(start_cnt - sbase), 1);
    @(negedge clk);
    checkOutput("m_valid_drop", m_valid, 0);
  endtask

  typedef struct {
    logic [127:0] plain;
    logic [127:0] key;
    bit           reuse;
    int           flat;
    int           beats;
    int           lat;
    bit           has_ct;
    logic [127:0] ct;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: sim time exceeded, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int           acc, acc2, hs, bb, sb, n, tb8, mv0;
    bit           stable, seen;
    logic [127:0] held, p5, k5, k0;

    k0 = 128'h000102030405060708090a0b0c0d0e0f;
    // Latency from accept edge to m_valid edge: 14+F with key writes, 10+F on reuse.
    vecs[0] = '{128'h00112233445566778899aabbccddeeff, k0, 1'b1, 3, 8, 17, 1'b1,
                128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{128'h0, k0, 1'b1, 1, 4, 11, 1'b0, 128'h0};
    vecs[2] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c,
                1'b0, 2, 8, 16, 1'b1, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[3] = '{128'h00000000_11111111_deadbeef_cafef00d, 128'hffffffff_00000000_ffffffff_00000000,
                1'b1, 6, 4, 16, 1'b0, 128'h0};
    vecs[4] = '{128'hffeeddcc_bbaa9988_77665544_33221100, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0,
                1'b0, 1, 8, 15, 1'b0, 128'h0};

    repeat (3) @(negedge clk);
    checkOutput("rst_s_ready", s_ready, 1);
    checkOutput("rst_wr", wr, 0);
    checkOutput("rst_start", start, 0);
    checkOutput("rst_m_valid", m_valid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_bus", {waddr, wdata, raddr}, 0);
    nrst = 1'b1;

    for (int i = 0; i < 5; i++) begin
      finish_lat = vecs[i].flat;
      bb = beat_log.size();
      sb = start_cnt;
      applyStimulus(vecs[i].plain, vecs[i].key, vecs[i].reuse, acc);
      if (vecs[i].has_ct) checkOutput("known_answer", exp_q[0], vecs[i].ct);
      collectResult(acc, vecs[i].lat, vecs[i].beats, bb, sb, vecs[i].plain, vecs[i].key);
    end

    // Backpressure: result held for 20 cycles, a waiting job enters only after the handshake.
    m_ready = 1'b0;
    finish_lat = 2;
    p5 = 128'h0123456789abcdef_fedcba9876543210;
    k5 = 128'h55555555_aaaaaaaa_12345678_9abcdef0;
    applyStimulus(128'hcafebabe_00000000_12121212_34343434, k5, 1'b0, acc);
    n = 0;
    while (!m_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp_m_valid", m_valid, 1);
    held = m_cipher;
    checkOutput("bp_cipher", held, (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx);
    s_plain = p5; s_key = k5; s_key_reuse = 1'b1; s_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!m_valid || m_cipher !== held || s_ready) stable = 1'b0;
    end
    checkOutput("bp_stable", stable, 1);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    hs = cyc;
    bb = beat_log.size();
    sb = start_cnt;
    applyStimulus(p5, k5, 1'b1, acc2);
    checkOutput("bp_accept_after_hs", 128'(acc2 - hs), 1);
    collectResult(acc2, 12, 4, bb, sb, p5, k5);

    // bus_free low for 50 cycles holds off start without raising err.
    bus_free_en = 1'b0;
    bb = beat_log.size();
    sb = start_cnt;
    applyStimulus(128'h1, k5, 1'b1, acc);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (start) seen = 1'b1;
    end
    checkOutput("busfree_start_held", seen, 0);
    bus_free_en = 1'b1;
    collectResult(acc, -1, 4, bb, sb, 128'h1, k5);
    checkOutput("busfree_no_err", err, 0);

    // TIMEOUT=15 instance: 15 WAIT_FIN cycles after START, err seen in the next cycle.
    tb8 = t_beat_cnt;
    @(negedge clk);
    s_plain = p5; s_key = k0; s_key_reuse = 1'b0; t_s_valid = 1'b1;
    @(posedge clk);
    #1;
    t_s_valid = 1'b0;
    n = 0;
    while (!t_start && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_start", t_start, 1);
    n = 0;
    while (!t_err && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_err_cycles", 128'(n), 16);
    checkOutput("tmo_idle", t_s_ready, 1);
    checkOutput("tmo_beats", 128'(t_beat_cnt - tb8), 8);
    tb8 = t_beat_cnt;
    @(negedge clk);
    s_key_reuse = 1'b1; t_s_valid = 1'b1;
    @(posedge clk);
    #1;
    t_s_valid = 1'b0;
    checkOutput("tmo_err_cleared", t_err, 0);
    n = 0;
    while (!t_err && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("tmo_key_rewritten", 128'(t_beat_cnt - tb8), 8);
    checkOutput("tmo_no_m_valid", 128'(t_mv_cycles), 0);

    // Reset during the key writes abandons the job and forgets the loaded key.
    finish_lat = 2;
    applyStimulus(vecs[4].plain, vecs[2].key, 1'b0, acc);
    n = 0;
    while (!(wr && waddr == 3'd5) && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rst_mid_reached_key", {wr, waddr}, {1'b1, 3'd5});
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", {wr, waddr, wdata, raddr, start, m_valid, err}, 0);
    checkOutput("rst_mid_cipher", m_cipher, 0);
    exp_q.delete();
    mdl_kl = 1'b0;
    mv0 = mv_cycles;
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("rst_mid_s_ready", s_ready, 1);
    repeat (30) @(negedge clk);
    checkOutput("rst_mid_no_m_valid", 128'(mv_cycles - mv0), 0);
    bb = beat_log.size();
    sb = start_cnt;
    applyStimulus(vecs[3].plain, vecs[4].key, 1'b1, acc);
    collectResult(acc, 16, 8, bb, sb, vecs[3].plain, vecs[4].key);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_host.md
Name: aes_encrypt_host

Overview:
- Bus-initiator counterpart to the AES encrypt top-level register port.
- Accepts a 128-bit plaintext/key job on a valid/ready stream and writes it as eight 32-bit words over the wr/waddr/in port.
- Then pulses start, waits for finish, and reads the ciphertext back as four words via raddr/out.
- Returns the ciphertext on a valid/ready output stream; sits between a stream source/sink and the encrypt top.

Parameters:
- TIMEOUT, 1023: max cycles spent in each of WAIT_FREE and WAIT_FIN before abort; 0 disables the timeout.
- TW, 10: timeout counter width; must satisfy TIMEOUT < 2^TW.

Ports:
- clk  input  1  clock; all logic on posedge.
- nrst  input  1  reset, asynchronous, active-low.
- s_valid  input  1  job request.
- s_ready  output  1  job accept; high only in IDLE.
- s_plain  input  128  plaintext.
- s_key  input  128  key.
- s_key_reuse  input  1  skip key writes if a key is already loaded.
- m_valid  output  1  ciphertext valid.
- m_ready  input  1  ciphertext consumed.
- m_cipher  output  128  ciphertext.
- err  output  1  timeout flag, sticky until next job accept.
- wr  output  1  write strobe to core port.
- waddr  output  3  write word address (0-3 plaintext, 4-7 key).
- wdata  output  32  write data (drives the core's in).
- raddr  output  2  read word select.
- rdata  input  32  read data (from the core's out).
- start  output  1  one-cycle start pulse.
- finish  input  1  core done.
- bus_free  input  1  core idle and able to accept start.

Behaviour:
- Reset (async, nrst=0) values:
  - State=IDLE, so s_ready=1.
  - wr=0, waddr=0, wdata=0, raddr=0, start=0.
  - m_valid=0, m_cipher=0, err=0, key_loaded=0.
- Reset mid-operation abandons the job with no outputs, and clears key_loaded.
- All port outputs are registered. s_ready is decoded from state.
- States: IDLE, WR_PT, WR_KEY, WAIT_FREE, START, WAIT_FIN, RD, OUT.
- IDLE:
  - On s_valid & s_ready (edge T): latch s_plain and s_key, clear err, go to WR_PT.
  - Set skip_key = s_key_reuse & key_loaded.
- WR_PT: wr=1 for 4 cycles T+1..T+4, waddr=0..3, wdata=plain[32i+31:32i] on beat i.
- WR_KEY:
  - Entered unless skip_key: 4 beats, waddr=4..7, wdata=key[32i+31:32i].
  - key_loaded is set on the last key beat.
  - If skip_key, goes straight from WR_PT to WAIT_FREE.
- wr=0 in every state other than WR_PT and WR_KEY.
- WAIT_FREE:
  - Stays until bus_free is sampled 1, then goes to START.
  - The timeout counter runs in this state.
- START: start=1 for exactly one cycle, then WAIT_FIN.
- WAIT_FIN:
  - Completion is finish sampled 1 in any cycle after the start cycle; finish on the start cycle itself is ignored.
  - finish may be a pulse or a level; the first sampled 1 counts.
  - On completion, go to RD.
- RD:
  - 4 cycles; raddr=k in cycle k, for k=0..3.
  - The edge ending cycle k captures rdata into m_cipher[32k+31:32k].
- OUT:
  - m_valid=1 and m_cipher stay stable until m_valid & m_ready, then IDLE.
  - s_ready is 0 while in OUT; no overlap of jobs.
- Timeout:
  - Counter clears on entry to WAIT_FREE and to WAIT_FIN.
  - When it reaches TIMEOUT: err=1, go to IDLE, m_valid is not asserted, key_loaded is cleared.
- Latency with m_ready=1, bus_free=1, finish arriving F cycles after start:
  - Full job (key written): m_valid rises 8+1+1+F+4 cycles after accept.
  - With key reuse: 4 cycles less.
- s_valid while not in IDLE is ignored (s_ready=0).
- raddr holds its last value outside RD.

Test Plan:
- FIPS-197 vector against the real encrypt top:
  - Stimulus: plain=00112233445566778899aabbccddeeff, key=000102030405060708090a0b0c0d0e0f.
  - Bus: waddr0 gets ccddeeff, waddr7 gets 00010203; exactly one start pulse.
  - Response: m_cipher=69c4e0d86a7b0430d8cdb78070b4c55a.
- Key reuse:
  - Second job with s_key_reuse=1 and plain=0 produces only 4 wr beats (waddr 0-3).
  - Result matches the reference model of AES(0, same key).
  - The same request immediately after reset writes all 8 words.
- Backpressure:
  - Hold m_ready=0 for 20 cycles: m_valid and m_cipher stay stable, s_ready=0.
  - A new s_valid is not accepted until the cycle after the handshake.
- bus_free held 0 for 50 cycles: start stays 0, then pulses exactly once after bus_free rises; no err.
- Timeout with TIMEOUT=15 and finish tied 0:
  - err=1 at 15 cycles after START, return to IDLE, m_valid never asserts.
  - The next job clears err and rewrites the key even with s_key_reuse=1.
- Reset mid-job: nrst pulsed low during WR_KEY → all outputs at reset values immediately, s_ready=1 after release, no m_valid.
